// File: rtl/ascii_time_parser.sv
// rtl/ascii_time_parser.sv - parses "THH:MM:SS"+CR/LF byte frames into a packed time word
module ascii_time_parser #(
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [23:0] o_time,
    output logic        o_load,
    output logic        o_err,
    output logic        o_busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, H1, H0, C1, M1, M0, C2, S1, S0, TERM
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     tens_q, tens_d;
    logic [4:0]     hour_q, hour_d;
    logic [5:0]     min_q, min_d;
    logic [5:0]     sec_q, sec_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [23:0]    time_q, time_d;
    logic           load_q, load_d;
    logic           err_q, err_d;
    logic           busy_q;

    logic           is_digit;
    logic           is_t;
    logic           is_term;
    logic [6:0]     field;
    logic           bad;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_t     = (rx_data == 8'h54) || (rx_data == 8'h74);
    assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    // tens*10 + ones as (tens<<3) + (tens<<1) + ones
    assign field    = {tens_q, 3'b000} + {2'b00, tens_q, 1'b0} + {3'b000, rx_data[3:0]};

    // next-state, field capture, range checks and inter-byte timeout
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        timer_d = timer_q;
        time_d  = time_q;
        load_d  = 1'b0;
        err_d   = 1'b0;
        bad     = 1'b0;
        if (state_q == IDLE) begin
            timer_d = '0;
            if (rx_done && is_t) begin
                state_d = H1;
            end
        end else if (rx_done) begin
            timer_d = '0;
            if (is_t) begin
                // resync: abort the current frame and start a new one with this byte
                err_d   = 1'b1;
                state_d = H1;
            end else begin
                case (state_q)
                    H1, M1, S1: begin
                        if (is_digit) begin
                            tens_d  = rx_data[3:0];
                            state_d = state_t'(state_q + 4'd1);
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    H0: begin
                        if (is_digit && field <= 7'd23) begin
                            hour_d  = field[4:0];
                            state_d = C1;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    M0: begin
                        if (is_digit && field <= 7'd59) begin
                            min_d   = field[5:0];
                            state_d = C2;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    S0: begin
                        if (is_digit && field <= 7'd59) begin
                            sec_d   = field[5:0];
                            state_d = TERM;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    C1, C2: begin
                        if (rx_data == 8'h3A) begin
                            state_d = state_t'(state_q + 4'd1);
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    TERM: begin
                        if (is_term) begin
                            time_d  = {hour_q, min_q, sec_q, 7'd0};
                            load_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    default: bad = 1'b1;
                endcase
                if (bad) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
        end else if (timer_q == TIMER_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    // state, field and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tens_q  <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            timer_q <= '0;
            time_q  <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            timer_q <= timer_d;
            time_q  <= time_d;
            load_q  <= load_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign o_time = time_q;
    assign o_load = load_q;
    assign o_err  = err_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_ascii_time_parser.sv
// tb/tb_ascii_time_parser.sv - table, directed and random checks of ascii_time_parser
module tb_ascii_time_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic [23:0] o_time;
    logic        o_load;
    logic        o_err;
    logic        o_busy;

    ascii_time_parser #(.TIMEOUT_CYCLES(1000)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .o_time  (o_time),
        .o_load  (o_load),
        .o_err   (o_err),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int loads_seen = 0;
    int errs_seen = 0;

    // reference model: position within "T" + "HH:MM:SS" + terminator, digit storage
    int          m_pos = 0;
    int          m_dig [1:8];
    logic [23:0] m_time = 24'd0;

    typedef struct {
        logic [127:0] bytes;
        int           len;
        int           loads;
        int           errs;
        logic [23:0]  time_v;
    } vec_t;

    vec_t tab [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, output logic el, output logic ee);
        bit is_t;
        bit ok;
        int v;
        el = 1'b0;
        ee = 1'b0;
        is_t = (b == "T") || (b == "t");
        if (m_pos == 0) begin
            if (is_t) m_pos = 1;
            return;
        end
        if (is_t) begin
            ee = 1'b1;
            m_pos = 1;
            return;
        end
        if (m_pos == 3 || m_pos == 6)  ok = (b == ":");
        else if (m_pos == 9)           ok = (b == 8'h0D) || (b == 8'h0A);
        else                           ok = (b >= "0") && (b <= "9");
        if (!ok) begin
            ee = 1'b1;
            m_pos = 0;
            return;
        end
        if (m_pos != 3 && m_pos != 6 && m_pos != 9) m_dig[m_pos] = int'(b) - 48;
        if (m_pos == 2 || m_pos == 5 || m_pos == 8) begin
            v = m_dig[m_pos-1] * 10 + m_dig[m_pos];
            if (v > ((m_pos == 2) ? 23 : 59)) begin
                ee = 1'b1;
                m_pos = 0;
                return;
            end
        end
        if (m_pos == 9) begin
            el = 1'b1;
            m_time = 24'((m_dig[1]*10 + m_dig[2]) * 524288 + (m_dig[4]*10 + m_dig[5]) * 8192
                        + (m_dig[7]*10 + m_dig[8]) * 128);
            m_pos = 0;
            return;
        end
        m_pos++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic el, ee;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        model_byte(b, el, ee);
        loads_seen += int'(o_load);
        errs_seen  += int'(o_err);
        check("load", {31'd0, o_load}, {31'd0, el});
        check("err", {31'd0, o_err}, {31'd0, ee});
        check("busy", {31'd0, o_busy}, {31'd0, m_pos != 0});
        check("time", {8'd0, o_time}, {8'd0, m_time});
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        check("idle_strobes", {30'd0, o_load, o_err}, 32'd0);
    endtask

    task automatic send_str(input logic [127:0] s, input int len);
        for (int i = 0; i < len; i++) send_byte(s[8*(len-1-i) +: 8]);
    endtask

    initial begin
        logic [7:0] fr [10];
        int h, m, s, n;

        tab[0] = '{"t23:59:59\012", 10, 1, 0, 24'hBF7D80};
        tab[1] = '{"T12:34:56\015", 10, 1, 0, 24'h645C00};
        tab[2] = '{"T24:00:00\015", 10, 0, 1, 24'h645C00};
        tab[3] = '{"T12:3T01:02:03\015", 15, 1, 1, 24'h084180};
        tab[4] = '{"T12:60:00\015", 10, 0, 1, 24'h084180};
        tab[5] = '{"T12A", 4, 0, 1, 24'h084180};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {o_time, 5'd0, o_load, o_err, o_busy}, 32'd0);
        reset = 1'b1;
        idle_cycle();

        for (int t = 0; t < 6; t++) begin
            loads_seen = 0;
            errs_seen = 0;
            send_str(tab[t].bytes, tab[t].len);
            idle_cycle();
            check($sformatf("tab%0d_loads", t), loads_seen, tab[t].loads);
            check($sformatf("tab%0d_errs", t), errs_seen, tab[t].errs);
            check($sformatf("tab%0d_time", t), {8'd0, o_time}, {8'd0, tab[t].time_v});
            check($sformatf("tab%0d_busy", t), {31'd0, o_busy}, 32'd0);
        end

        // inter-byte timeout: error after exactly 1000 idle cycles
        send_str("T12:", 4);
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (o_err) break;
        end
        check("timeout_latency", n, 1000);
        check("timeout_busy", {31'd0, o_busy}, 32'd0);
        m_pos = 0;
        idle_cycle();

        // byte arriving in the expiry cycle wins over the timeout
        send_str("T1", 2);
        repeat (999) idle_cycle();
        errs_seen = 0;
        send_str("2:00:00\015", 8);
        check("expiry_byte_errs", errs_seen, 0);
        check("expiry_byte_time", {8'd0, o_time}, 32'h600000);

        // reset mid-frame clears everything asynchronously
        send_str("T12:3", 5);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", {o_time, 5'd0, o_load, o_err, o_busy}, 32'd0);
        m_pos = 0;
        m_time = 24'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", {o_time, 5'd0, o_load, o_err, o_busy}, 32'd0);
        reset = 1'b1;
        idle_cycle();
        loads_seen = 0;
        send_str("T00:00:01\015", 10);
        check("post_reset_loads", loads_seen, 1);
        check("post_reset_time", {8'd0, o_time}, 32'h000080);

        // random frames, some out of range or corrupted, random gaps
        for (int f = 0; f < 250; f++) begin
            h = $urandom_range(0, 29);
            m = $urandom_range(0, 69);
            s = $urandom_range(0, 69);
            fr[0] = ($urandom_range(0, 1) == 0) ? "T" : "t";
            fr[1] = 8'(48 + h / 10);
            fr[2] = 8'(48 + h % 10);
            fr[3] = ":";
            fr[4] = 8'(48 + m / 10);
            fr[5] = 8'(48 + m % 10);
            fr[6] = ":";
            fr[7] = 8'(48 + s / 10);
            fr[8] = 8'(48 + s % 10);
            fr[9] = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
            if ($urandom_range(0, 7) == 0) fr[$urandom_range(0, 9)] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) send_byte(8'($urandom_range(0, 255)));
            for (int i = 0; i < 10; i++) begin
                send_byte(fr[i]);
                repeat ($urandom_range(0, 2)) idle_cycle();
            end
        end
        idle_cycle();
        check("final_busy", {31'd0, o_busy}, {31'd0, m_pos != 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // strobes must be mutually exclusive at every sample point
    always @(negedge clk) begin
        if (reset && o_load && o_err) begin
            n_cmp++;
            n_bad++;
            $display("FAIL load_err_exclusive: got both 1 expected at most one at %0t", $time);
        end
    end

endmodule
